// File: rtl/pc_redirect_unit.sv
// Fetch PC register with sequential increment and delayed, supersedable redirect.
// Latency: registered outputs; a redirect sampled at edge E lands in pc_o after edge E+REDIRECT_DELAY.
// Backpressure: no handshake; stall_i freezes the increment only, never the redirect countdown.
module pc_redirect_unit #(
  parameter int                XLEN           = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR   = 32'h0000_0000,
  parameter int                REDIRECT_DELAY = 3,
  parameter int                INC_STEP       = 4,
  parameter int                ALIGN_BITS     = 2
) (
  input  logic            clk_i,
  input  logic            i_rst,
  input  logic            stall_i,
  input  logic            inc_en_i,
  input  logic            redirect_en_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pending_o,
  output logic [3:0]      remaining_o,
  output logic            commit_o,
  output logic            misalign_o
);

  typedef enum logic {IDLE, COUNT} state_t;

  // Low-bit mask built by shift so ALIGN_BITS=0 (no alignment check) stays legal.
  localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
  localparam logic [XLEN-1:0] INC        = XLEN'(INC_STEP);
  localparam logic [3:0]      DELAY_M1   = (REDIRECT_DELAY > 0) ? 4'(REDIRECT_DELAY - 1) : 4'd0;
  localparam bit              IMMEDIATE  = (REDIRECT_DELAY == 0);

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic [3:0]      remaining;
  logic            commit;
  logic            misalign;

  logic            aligned;
  logic            accept;
  logic            misaligned_req;
  logic            commit_now;
  logic            load;
  logic            inc_ok;
  logic [XLEN-1:0] load_value;

  // Flush outranks everything; a flushed redirect is neither accepted nor flagged.
  assign aligned        = (redirect_addr_i & ALIGN_MASK) == '0;
  assign accept         = redirect_en_i & ~flush_i & aligned;
  assign misaligned_req = redirect_en_i & ~flush_i & ~aligned;
  assign commit_now     = (state == COUNT) && (remaining == 4'd0) && !flush_i;
  assign load           = commit_now || (IMMEDIATE && accept);
  assign inc_ok         = inc_en_i & ~stall_i;
  // Only one load source can be live: commit needs COUNT, which an immediate build never enters.
  assign load_value     = commit_now ? target : redirect_addr_i;

  // Redirect FSM, PC register and pulse outputs share one registered update.
  always_ff @(posedge clk_i or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      pc        <= RESET_VECTOR;
      target    <= '0;
      remaining <= 4'd0;
      commit    <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      commit   <= load;
      misalign <= misaligned_req;

      if (load) begin
        pc <= load_value;
      end else if (inc_ok) begin
        pc <= pc + INC;
      end

      if (flush_i) begin
        state     <= IDLE;
        remaining <= 4'd0;
      end else if (accept && !IMMEDIATE) begin
        // Newest redirect wins, including on the edge the previous one commits.
        state     <= COUNT;
        target    <= redirect_addr_i;
        remaining <= DELAY_M1;
      end else if (state == COUNT) begin
        if (remaining == 4'd0) begin
          state <= IDLE;
        end else begin
          remaining <= remaining - 4'd1;
        end
      end
    end
  end

  assign pc_o        = pc;
  assign pending_o   = (state == COUNT);
  assign remaining_o = remaining;
  assign commit_o    = commit;
  assign misalign_o  = misalign;

endmodule
